// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder-to-sequencer strobe and status bundle
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                pc_en;
    logic                jmp;
    logic                br;
    logic                br_cond;
    logic                call;
    logic                ret;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc;
    logic                stack_empty;
    logic                stack_full;
    logic                stack_err;

    // Decoder side: issues strobes, observes pc and stack status
    modport master (
        output pc_en, jmp, br, br_cond, call, ret, target,
        input  pc, stack_empty, stack_full, stack_err
    );

    // Sequencer side: consumes strobes, owns pc and stack status
    modport slave (
        input  pc_en, jmp, br, br_cond, call, ret, target,
        output pc, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, fetch sequencing and hardware return stack
module pc_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           res_n,
    pc_sequencer_if.slave  bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);
    localparam logic [SP_W-1:0]     SP_ONE    = SP_W'(1);
    localparam logic [SP_W-1:0]     SP_FULL   = SP_W'(STACK_DEPTH);

    // Winning command after priority resolution (ret > call > jmp > br > increment)
    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_JMP,
        CMD_CALL,
        CMD_RET
    } cmd_e;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                err_q, err_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];

    cmd_e                cmd;
    logic                sp_empty;
    logic                sp_full;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [SP_W-1:0]     sp_dec;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    pop_idx;

    // Status decodes straight from the registered stack pointer
    assign sp_empty = (sp_q == '0);
    assign sp_full  = (sp_q == SP_FULL);
    assign pc_inc   = pc_q + PC_ONE;
    assign sp_dec   = sp_q - SP_ONE;
    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = sp_dec[IDX_W-1:0];

    // Resolve simultaneous strobes to a single command; stall masks everything
    always_comb begin
        cmd = CMD_HOLD;
        if (bus.pc_en) begin
            if (bus.ret) begin
                cmd = CMD_RET;
            end else if (bus.call) begin
                cmd = CMD_CALL;
            end else if (bus.jmp) begin
                cmd = CMD_JMP;
            end else if (bus.br && bus.br_cond) begin
                cmd = CMD_JMP;
            end else begin
                cmd = CMD_INC;
            end
        end
    end

    // Next pc, stack pointer and sticky error; misuse degrades to a plain increment
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        case (cmd)
            CMD_INC: begin
                pc_d = pc_inc;
            end
            CMD_JMP: begin
                pc_d = bus.target;
            end
            CMD_CALL: begin
                if (sp_full) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d = bus.target;
                    sp_d = sp_q + SP_ONE;
                end
            end
            CMD_RET: begin
                if (sp_empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d = stack_q[pop_idx];
                    sp_d = sp_dec;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Return-address write: only a successful call pushes pc+1
    always_comb begin
        stack_d = stack_q;
        if (cmd == CMD_CALL && !sp_full) begin
            stack_d[push_idx] = pc_inc;
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage is deliberately left uninitialised by reset
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.pc          = pc_q;
    assign bus.stack_empty = sp_empty;
    assign bus.stack_full  = sp_full;
    assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a queue-based model
module tb_pc_sequencer;
    localparam int PW    = 8;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << PW) - 1;

    typedef struct {
        int pc;
        bit empty;
        bit full;
        bit err;
    } exp_t;

    logic clk;
    logic res_n;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];
    int   m_pc;
    int   m_stk[$];
    bit   m_err;

    pc_sequencer_if #(.PC_WIDTH(PW)) bus ();

    pc_sequencer #(.PC_WIDTH(PW), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_err = 0;
    endtask

    // Reference behaviour: stack as a queue, pc as a plain integer
    task automatic model_step(input bit en, input bit j, input bit b, input bit bc,
                              input bit c, input bit r, input int t);
        if (en) begin
            if (r) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = (m_pc + 1) & MASK; m_err = 1; end
            end else if (c) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_pc + 1) & MASK);
                    m_pc = t & MASK;
                end else begin
                    m_pc = (m_pc + 1) & MASK; m_err = 1;
                end
            end else if (j || (b && bc)) begin
                m_pc = t & MASK;
            end else begin
                m_pc = (m_pc + 1) & MASK;
            end
        end
    endtask

    // Apply one cycle of strobes at the falling edge and queue the expected outcome
    task automatic drive(input bit en, input bit j, input bit b, input bit bc,
                         input bit c, input bit r, input int t);
        exp_t e;
        @(negedge clk);
        bus.pc_en   = en;
        bus.jmp     = j;
        bus.br      = b;
        bus.br_cond = bc;
        bus.call    = c;
        bus.ret     = r;
        bus.target  = PW'(t);
        model_step(en, j, b, bc, c, r, t);
        e.pc    = m_pc;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DEPTH);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic expect_state(input string nm, input int pc, input bit em,
                                input bit fu, input bit er);
        @(posedge clk);
        #2;
        check({nm, "_pc"}, int'(bus.pc), pc);
        check({nm, "_empty"}, int'(bus.stack_empty), int'(em));
        check({nm, "_full"}, int'(bus.stack_full), int'(fu));
        check({nm, "_err"}, int'(bus.stack_err), int'(er));
    endtask

    task automatic idle_inputs();
        bus.pc_en   = 1'b0;
        bus.jmp     = 1'b0;
        bus.br      = 1'b0;
        bus.br_cond = 1'b0;
        bus.call    = 1'b0;
        bus.ret     = 1'b0;
        bus.target  = '0;
    endtask

    // Pull reset between clock edges and confirm it acts without waiting for clk
    task automatic async_reset(input string nm);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #3;
        res_n = 1'b0;
        #1;
        check({nm, "_pc"}, int'(bus.pc), 0);
        check({nm, "_empty"}, int'(bus.stack_empty), 1);
        check({nm, "_full"}, int'(bus.stack_full), 0);
        check({nm, "_err"}, int'(bus.stack_err), 0);
        model_reset();
        @(negedge clk);
        res_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT has an outstanding expectation, compare it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_pc", int'(bus.pc), e.pc);
                check("mon_empty", int'(bus.stack_empty), int'(e.empty));
                check("mon_full", int'(bus.stack_full), int'(e.full));
                check("mon_err", int'(bus.stack_err), int'(e.err));
            end
        end
    end

    initial begin
        res_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check("reset_pc", int'(bus.pc), 0);
        check("reset_empty", int'(bus.stack_empty), 1);
        check("reset_full", int'(bus.stack_full), 0);
        check("reset_err", int'(bus.stack_err), 0);
        @(negedge clk);
        res_n = 1'b1;

        // Free-running increment through the 8-bit wrap
        for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 0, 0, 0);
        expect_state("wrap", 300 & MASK, 1, 0, 0);

        // Stall ignores a pending jump
        drive(1, 1, 0, 0, 0, 0, 8'h05);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 8'h40);
        expect_state("stall", 8'h05, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 8'h40);
        expect_state("jmp", 8'h40, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        expect_state("jmp_next", 8'h41, 1, 0, 0);

        // Conditional branch not taken, then taken
        drive(1, 1, 0, 0, 0, 0, 8'h10);
        drive(1, 0, 1, 0, 0, 0, 8'h03);
        expect_state("br_nt", 8'h11, 1, 0, 0);
        drive(1, 0, 1, 1, 0, 0, 8'h03);
        expect_state("br_t", 8'h03, 1, 0, 0);

        // Nested call/return
        drive(1, 1, 0, 0, 0, 0, 8'h20);
        drive(1, 0, 0, 0, 1, 0, 8'h80);
        expect_state("call1", 8'h80, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 8'h90);
        expect_state("call2", 8'h90, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_state("ret1", 8'h81, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_state("ret2", 8'h21, 1, 0, 0);

        // Overflow then underflow
        drive(1, 0, 0, 0, 1, 0, 8'h10);
        drive(1, 0, 0, 0, 1, 0, 8'h20);
        drive(1, 0, 0, 0, 1, 0, 8'h30);
        drive(1, 0, 0, 0, 1, 0, 8'h50);
        expect_state("fill", 8'h50, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0, 8'h99);
        expect_state("overflow", 8'h51, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_state("unwind1", 8'h31, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1, 0);
        expect_state("unwind4", 8'h22, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 1, 0);
        expect_state("underflow", 8'h23, 1, 0, 1);

        // ret beats jmp when the stack holds an entry
        drive(1, 0, 0, 0, 1, 0, 8'h70);
        drive(1, 1, 0, 0, 0, 1, 8'h05);
        expect_state("prio_ret", 8'h24, 1, 0, 1);
        drive(1, 0, 0, 0, 1, 0, 8'h60);
        async_reset("async_rst");

        // Randomized strobes, with a reset midway to clear the sticky error
        for (int i = 0; i < 1600; i++) begin
            if (i == 800) async_reset("async_rst2");
            drive(($urandom % 5) != 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
                  ($urandom % 2) == 0, ($urandom % 5) == 0, ($urandom % 5) == 0,
                  int'($urandom % 256));
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and fetch sequencer that sits directly upstream of Program_Mem. Its registered pc output drives the Program_Mem pc input.
- Program_Mem returns ir one clock after pc changes.
- The decoder issues control strobes to this block: jump, conditional branch, call, return and stall.
- A small hardware return stack supports call/return.
- Stack misuse is flagged sticky rather than corrupting the PC.

Parameters:
PC_WIDTH, 8, width of program counter and all addresses (matches Program_Mem).
STACK_DEPTH, 4, number of return-address entries (power of two, >=2).

Ports:
clk  input  1  system clock, rising-edge.
res_n  input  1  asynchronous active-low reset.
pc_en  input  1  advance enable; 0 = stall (pc, stack, flags hold).
jmp  input  1  unconditional jump to target.
br  input  1  conditional branch to target if br_cond.
br_cond  input  1  branch condition (flag from ALU).
call  input  1  push return address, jump to target.
ret  input  1  pop return address into pc.
target  input  PC_WIDTH  jump/branch/call destination.
pc  output  PC_WIDTH  registered program counter to Program_Mem.
stack_empty  output  1  no entries on return stack.
stack_full  output  1  STACK_DEPTH entries on return stack.
stack_err  output  1  sticky: overflow or underflow occurred.

Behaviour:
Reset:
- res_n low, asynchronous: pc=0, stack pointer=0, stack_empty=1, stack_full=0, stack_err=0.
- Stack RAM contents are not cleared.
- After release, the first Program_Mem ir is the word at address 0.

General update rules:
- All updates happen on the rising edge of clk, and only when pc_en=1.
- pc_en=0: all state holds and all strobes are ignored.

Command priority when several strobes are high: ret > call > jmp > br > increment. Only the winning command takes effect.
- Increment (no strobe, or br with br_cond=0): pc <= pc+1, modulo 2^PC_WIDTH. 2^PC_WIDTH-1 wraps to 0.
- jmp: pc <= target.
- br && br_cond: pc <= target. br && !br_cond: increment.
- call, stack not full:
  - stack[sp] <= pc+1 (wrapping), then sp <= sp+1.
  - pc <= target.
- call, stack full:
  - No push, no jump; pc <= pc+1.
  - stack_err <= 1.
- ret, stack not empty:
  - sp <= sp-1, then pc <= stack[sp-1].
- ret, stack empty:
  - No pop; pc <= pc+1.
  - stack_err <= 1.

Stack and flags:
- stack_empty = (sp==0) and stack_full = (sp==STACK_DEPTH). Both decode combinationally from the registered sp.
- sp is $clog2(STACK_DEPTH)+1 bits wide.
- stack_err clears only on reset.

Latency:
- A strobe sampled at edge N sets pc at edge N.
- Program_Mem presents the new ir after edge N+1.
- The decoder must mask the one already-fetched word after a taken transfer. That masking is not done here.

Reset mid-operation: asynchronous. pc and sp return to 0 immediately, regardless of clk or pending strobes.

Test Plan:
1. Reset, then pc_en=1 with no strobes for 300 cycles -> pc runs 0,1,…,255,0,1,… (wrap at 255 to 0). stack_empty=1, stack_err=0 throughout.
2. Stall: pc=5, pc_en=0 for 3 cycles with jmp=1, target=0x40 -> pc stays 5. Then pc_en=1, jmp=1 -> pc=0x40. Next cycle, no strobe -> 0x41.
3. Branch: pc=0x10, br=1, br_cond=0 -> pc=0x11. Then br=1, br_cond=1, target=0x03 -> pc=0x03.
4. Call/return nesting: from pc=0x20, call target=0x80; at 0x80, call target=0x90; at 0x90, ret; then ret.
   - pc sequence: 0x80, 0x90, 0x81, 0x21.
   - stack_empty goes 1→0→0→0→1.
5. Overflow/underflow:
   - Four calls fill the stack -> stack_full=1.
   - Fifth call at pc=0x50 -> pc=0x51, stack_err=1, sp unchanged.
   - Four rets unwind correctly; a fifth ret at pc=p -> pc=p+1, stack_err stays 1.
6. Priority and async reset: ret and jmp together with a non-empty stack -> ret wins. Assert res_n=0 mid-cycle -> pc=0, stack_empty=1, stack_err=0 immediately, before the next clk edge.
